// File: rtl/field_packer.sv
// field_packer: streaming MSB-first bit-field packer.
// Concatenates IN_W-bit fields into OUT_W-bit words; the final word of a
// packet is padded at its LSB end with PAD_BIT.
// Optional macro FIELD_PACKER_PAD_CNT_EN adds out_pad_bits (padding count
// of the final word).
module field_packer #(
  parameter int   IN_W    = 5,
  parameter int   OUT_W   = 8,
  parameter logic PAD_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last
`ifdef FIELD_PACKER_PAD_CNT_EN
  ,
  output logic [$clog2(OUT_W+1)-1:0] out_pad_bits
`endif
);

  localparam int ACC_W = OUT_W + IN_W - 1;
  localparam int CW    = $clog2(ACC_W + 1);
  localparam logic [CW-1:0] OUT_C = CW'(OUT_W);
  localparam logic [CW-1:0] IN_C  = CW'(IN_W);

  typedef enum logic {FILL, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              flush;
  logic              pop, push;
  logic [ACC_W-1:0]  ins;

  // Output decode from registered state only; in_data never reaches outputs.
  always_comb begin
    flush     = (state_q == FLUSH);
    out_valid = (cnt_q >= OUT_C) || (flush && cnt_q != '0);
    out_last  = flush && (cnt_q <= OUT_C) && (cnt_q != '0);
    // out_ready feeds in_ready directly so a full word can drain and a new
    // field enter in the same cycle (1 field/cycle sustained).
    in_ready  = !flush && ((cnt_q < OUT_C) || out_ready);
    for (int j = 0; j < OUT_W; j++) begin
      if (flush && (cnt_q < OUT_C) && (j < OUT_W - int'(cnt_q)))
        out_data[j] = PAD_BIT;
      else
        out_data[j] = acc_q[ACC_W-OUT_W+j];
    end
  end

`ifdef FIELD_PACKER_PAD_CNT_EN
  // Number of padded LSBs in the final word of a packet.
  always_comb begin
    out_pad_bits = '0;
    if (out_last && (cnt_q < OUT_C))
      out_pad_bits = ($clog2(OUT_W+1))'(OUT_W - int'(cnt_q));
  end
`endif

  // Next state: pop (shift out a word) is applied before push (append field).
  always_comb begin
    pop     = out_valid && out_ready;
    push    = in_valid && in_ready;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    ins     = '0;
    if (pop) begin
      acc_d = acc_q << OUT_W;
      cnt_d = (cnt_q > OUT_C) ? cnt_q - OUT_C : '0;
      if (out_last) state_d = FILL;
    end
    if (push) begin
      // Left-align the field, then drop it just below the held bits; the
      // region below cnt is always zero so OR is a plain write.
      ins[ACC_W-1 -: IN_W] = in_data;
      acc_d = acc_d | (ins >> cnt_d);
      cnt_d = cnt_d + IN_C;
      if (in_last) state_d = FLUSH;
    end
  end

  // State registers; reset discards any partial packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_field_packer.sv
// Testbench for field_packer: directed scenarios plus randomized packets
// checked against a bit-queue reference model.
module tb_field_packer;

  localparam int IN_W  = 5;
  localparam int OUT_W = 8;

  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;

  logic             in_valid = 0, in_ready, in_last = 0, out_valid, out_ready = 0, out_last;
  logic [IN_W-1:0]  in_data = '0;
  logic [OUT_W-1:0] out_data;

  logic             z_in_valid = 0, z_in_ready, z_in_last = 0, z_out_valid, z_out_ready = 0, z_out_last;
  logic [IN_W-1:0]  z_in_data = '0;
  logic [OUT_W-1:0] z_out_data;

`ifdef FIELD_PACKER_PAD_CNT_EN
  logic [3:0] out_pad_bits, z_out_pad_bits;
`endif

  field_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .PAD_BIT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef FIELD_PACKER_PAD_CNT_EN
    , .out_pad_bits(out_pad_bits)
`endif
  );

  field_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .PAD_BIT(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data), .in_last(z_in_last),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data), .out_last(z_out_last)
`ifdef FIELD_PACKER_PAD_CNT_EN
    , .out_pad_bits(z_out_pad_bits)
`endif
  );

  typedef struct {
    logic [OUT_W-1:0] d;
    logic             l;
    int               p;
  } word_t;

  int n_chk = 0;
  int n_err = 0;
  int stab_err = 0;

  word_t           exp_q[$];
  word_t           got_q[$];
  logic [IN_W-1:0] pend_d[$];
  logic            pend_l[$];

  // Values observed during the most recent driven cycle.
  logic             o_ir, o_ov, o_ol;
  logic [OUT_W-1:0] o_od;
  int               o_pb;

  // Reference: treat the stream as a flat bit sequence; each packet is cut
  // into OUT_W-bit words, the short tail padded with ones.
  function automatic void model();
    bit bits[$];
    exp_q.delete();
    foreach (pend_d[i]) begin
      for (int b = IN_W - 1; b >= 0; b--) bits.push_back(pend_d[i][b]);
      if (pend_l[i]) begin
        while (bits.size() > 0) begin
          word_t w;
          int n;
          n = (bits.size() < OUT_W) ? bits.size() : OUT_W;
          for (int k = 0; k < OUT_W; k++)
            w.d[OUT_W-1-k] = (k < n) ? bits.pop_front() : 1'b1;
          w.l = (bits.size() == 0);
          w.p = w.l ? OUT_W - n : 0;
          exp_q.push_back(w);
        end
      end
    end
  endfunction

  // Drive one cycle (called at posedge+1), sample mid-cycle, advance.
  task automatic drv(input logic v, input logic [IN_W-1:0] d, input logic l, input logic r);
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    #2;
    o_ir = in_ready; o_ov = out_valid; o_od = out_data; o_ol = out_last;
`ifdef FIELD_PACKER_PAD_CNT_EN
    o_pb = int'(out_pad_bits);
`else
    o_pb = 0;
`endif
    @(posedge clk); #1;
  endtask

  // Stream pend_* through the DUT with given valid/ready probabilities,
  // collecting popped words into got_q.
  task automatic run(input int vp, input int rp, output int timeout);
    int need;
    int cyc;
    logic stall;
    logic [OUT_W-1:0] sd;
    logic sl;
    need = exp_q.size(); cyc = 0; stall = 0; sd = '0; sl = 0; timeout = 0;
    got_q.delete();
    while (pend_d.size() > 0 || got_q.size() < need) begin
      logic v, r;
      logic [IN_W-1:0] d;
      logic l;
      v = (pend_d.size() > 0) && ($urandom_range(99) < vp);
      r = ($urandom_range(99) < rp);
      d = '0; l = 0;
      if (v) begin d = pend_d[0]; l = pend_l[0]; end
      drv(v, d, l, r);
      if (stall && (!o_ov || o_od !== sd || o_ol !== sl)) stab_err++;
      stall = o_ov && !r; sd = o_od; sl = o_ol;
      if (v && o_ir) begin void'(pend_d.pop_front()); void'(pend_l.pop_front()); end
      if (o_ov && r) got_q.push_back('{o_od, o_ol, o_pb});
      cyc++;
      if (cyc > 3000) begin timeout = 1; break; end
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic load(input logic [IN_W-1:0] d, input int n, input int last_idx);
    pend_d.delete(); pend_l.delete();
    for (int i = 0; i < n; i++) begin
      pend_d.push_back(d);
      pend_l.push_back(i == last_idx);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    #3;
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_chk++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_chk++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b want 0", out_last); end
`ifdef FIELD_PACKER_PAD_CNT_EN
    n_chk++; if (out_pad_bits !== 4'd0) begin n_err++; $display("FAIL reset_pad: got %0d want 0", out_pad_bits); end
`endif
    @(posedge clk); #1;
    rst = 0;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_six_fields();
    logic [OUT_W-1:0] ed[4];
    int to;
    ed = '{8'hF8, 8'h3E, 8'h0F, 8'h83};
    pend_d.delete(); pend_l.delete();
    for (int i = 0; i < 6; i++) begin
      pend_d.push_back((i % 2 == 0) ? 5'h1F : 5'h00);
      pend_l.push_back(i == 5);
    end
    model();
    run(100, 100, to);
    n_chk++; if (to !== 0 || got_q.size() !== 4) begin n_err++; $display("FAIL six_count: got %0d words (timeout %0d) want 4", got_q.size(), to); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      n_chk++; if (got_q[i].d !== ed[i]) begin n_err++; $display("FAIL six_data[%0d]: got %h want %h", i, got_q[i].d, ed[i]); end
      n_chk++; if (got_q[i].l !== (i == 3)) begin n_err++; $display("FAIL six_last[%0d]: got %b want %b", i, got_q[i].l, i == 3); end
`ifdef FIELD_PACKER_PAD_CNT_EN
      n_chk++; if (got_q[i].p !== ((i == 3) ? 2 : 0)) begin n_err++; $display("FAIL six_pad[%0d]: got %0d want %0d", i, got_q[i].p, (i == 3) ? 2 : 0); end
`endif
    end
  endtask

  task automatic test_single();
    int to;
    load(5'h15, 1, 0);
    model();
    run(100, 100, to);
    n_chk++; if (to !== 0 || got_q.size() !== 1) begin n_err++; $display("FAIL single_count: got %0d words want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_chk++; if (got_q[0].d !== 8'hAF || got_q[0].l !== 1'b1) begin n_err++; $display("FAIL single_word: got %h/%b want AF/1", got_q[0].d, got_q[0].l); end
`ifdef FIELD_PACKER_PAD_CNT_EN
      n_chk++; if (got_q[0].p !== 3) begin n_err++; $display("FAIL single_pad: got %0d want 3", got_q[0].p); end
`endif
    end
    #2;
    n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL single_idle: got in_ready %b out_valid %b want 1 0", in_ready, out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_aligned();
    int to;
    load(5'h1F, 8, 7);
    model();
    run(100, 100, to);
    n_chk++; if (to !== 0 || got_q.size() !== 5) begin n_err++; $display("FAIL aligned_count: got %0d words want 5", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 5; i++) begin
      n_chk++; if (got_q[i].d !== 8'hFF || got_q[i].l !== (i == 4)) begin n_err++; $display("FAIL aligned[%0d]: got %h/%b want FF/%b", i, got_q[i].d, got_q[i].l, i == 4); end
`ifdef FIELD_PACKER_PAD_CNT_EN
      n_chk++; if (got_q[i].p !== 0) begin n_err++; $display("FAIL aligned_pad[%0d]: got %0d want 0", i, got_q[i].p); end
`endif
    end
  endtask

  task automatic test_backpressure();
    drv(1, 5'h1F, 0, 0);
    drv(1, 5'h1F, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drv(1, 5'h1F, 1, 0);
      n_chk++; if (o_ir !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, o_ir); end
      n_chk++; if (o_ov !== 1'b1 || o_od !== 8'hFF) begin n_err++; $display("FAIL bp_hold[%0d]: got %b/%h want 1/FF", i, o_ov, o_od); end
    end
    drv(1, 5'h1F, 1, 1);
    n_chk++; if (o_ir !== 1'b1 || o_ov !== 1'b1 || o_od !== 8'hFF) begin n_err++; $display("FAIL bp_release: got ir %b ov %b od %h want 1 1 FF", o_ir, o_ov, o_od); end
    drv(0, 5'h00, 0, 1);
    n_chk++; if (o_ov !== 1'b1 || o_od !== 8'hFF || o_ol !== 1'b1) begin n_err++; $display("FAIL bp_tail: got %b/%h/%b want 1/FF/1", o_ov, o_od, o_ol); end
`ifdef FIELD_PACKER_PAD_CNT_EN
    n_chk++; if (o_pb !== 1) begin n_err++; $display("FAIL bp_pad: got %0d want 1", o_pb); end
`endif
    drv(0, 5'h00, 0, 1);
    n_chk++; if (o_ov !== 1'b0 || o_ir !== 1'b1) begin n_err++; $display("FAIL bp_idle: got ov %b ir %b want 0 1", o_ov, o_ir); end
  endtask

  task automatic test_reset_mid();
    int to;
    drv(1, 5'h1F, 0, 0);
    drv(1, 5'h1F, 0, 0);
    in_valid = 0;
    #2;
    rst = 1;
    #1;
    n_chk++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin n_err++; $display("FAIL rstmid_outputs: got %b/%h want 0/00", out_valid, out_data); end
    @(posedge clk); #1;
    rst = 0;
    load(5'h15, 1, 0);
    model();
    run(100, 100, to);
    n_chk++; if (to !== 0 || got_q.size() !== 1) begin n_err++; $display("FAIL rstmid_count: got %0d words want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_chk++; if (got_q[0].d !== 8'hAF || got_q[0].l !== 1'b1) begin n_err++; $display("FAIL rstmid_word: got %h/%b want AF/1", got_q[0].d, got_q[0].l); end
    end
  endtask

  task automatic test_pad_zero();
    int cyc;
    logic seen;
    seen = 0;
    z_out_ready = 1;
    z_in_valid = 1; z_in_data = 5'h15; z_in_last = 1;
    #2;
    n_chk++; if (z_in_ready !== 1'b1) begin n_err++; $display("FAIL pad0_in_ready: got %b want 1", z_in_ready); end
    @(posedge clk); #1;
    z_in_valid = 0; z_in_last = 0;
    for (cyc = 0; cyc < 10 && !seen; cyc++) begin
      #2;
      if (z_out_valid === 1'b1) begin
        seen = 1;
        n_chk++; if (z_out_data !== 8'hA8 || z_out_last !== 1'b1) begin n_err++; $display("FAIL pad0_word: got %h/%b want A8/1", z_out_data, z_out_last); end
      end
      @(posedge clk); #1;
    end
    n_chk++; if (!seen) begin n_err++; $display("FAIL pad0_timeout: got no word want A8"); end
  endtask

  task automatic test_random();
    int to;
    for (int round = 0; round < 6; round++) begin
      pend_d.delete(); pend_l.delete();
      for (int p = 0; p < 4; p++) begin
        int len;
        len = $urandom_range(12, 1);
        for (int f = 0; f < len; f++) begin
          pend_d.push_back(IN_W'($urandom_range(31)));
          pend_l.push_back(f == len - 1);
        end
      end
      model();
      stab_err = 0;
      run(70, 60, to);
      n_chk++; if (to !== 0 || got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rand%0d_count: got %0d words want %0d", round, got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_chk++;
        if (got_q[i].d !== exp_q[i].d || got_q[i].l !== exp_q[i].l) begin
          n_err++; $display("FAIL rand%0d_word[%0d]: got %h/%b want %h/%b", round, i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l);
        end
`ifdef FIELD_PACKER_PAD_CNT_EN
        n_chk++; if (got_q[i].p !== exp_q[i].p) begin n_err++; $display("FAIL rand%0d_pad[%0d]: got %0d want %0d", round, i, got_q[i].p, exp_q[i].p); end
`endif
      end
      n_chk++; if (stab_err !== 0) begin n_err++; $display("FAIL rand%0d_stable: got %0d changes want 0", round, stab_err); end
    end
  endtask

  initial begin
    test_reset();
    test_six_fields();
    test_single();
    test_aligned();
    test_backpressure();
    test_reset_mid();
    test_pad_zero();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
